// File: rtl/memory_flasher_mr_pkg.sv
// Shared state encoding and region-search helpers for the multi-region flasher.
package flasher_pkg;

  // Helpers operate on a fixed maximum width; callers zero-extend their masks.
  localparam int MAX_REGIONS = 32;
  localparam int MAX_REG_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } flasher_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_REG_W-1:0] idx;
  } region_hit_t;

  // Lowest set bit of mask (used to pick the first region of a run).
  function automatic region_hit_t lowest_set(input logic [MAX_REGIONS-1:0] mask);
    region_hit_t hit;
    hit.found = 1'b0;
    hit.idx   = {MAX_REG_W{1'b0}};
    for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        hit.found = 1'b1;
        hit.idx   = MAX_REG_W'(i);
      end
    end
    return hit;
  endfunction

  // Next set bit strictly above cur; scanning downwards lets the lowest match win.
  function automatic region_hit_t next_region(input logic [MAX_REGIONS-1:0] mask,
                                              input logic [MAX_REG_W-1:0]   cur);
    region_hit_t hit;
    hit.found = 1'b0;
    hit.idx   = {MAX_REG_W{1'b0}};
    for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        hit.found = 1'b1;
        hit.idx   = MAX_REG_W'(i);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/memory_flasher_mr_region_select.sv
// Priority search over a region mask: first set bit, or next set bit above cur.
module flash_region_select
  import flasher_pkg::*;
#(
  parameter int NUM_REGIONS = 2,
  parameter int REG_W       = 1
) (
  input  logic [NUM_REGIONS-1:0] mask,
  input  logic [REG_W-1:0]       cur,
  input  logic                   first,
  output logic                   found,
  output logic [REG_W-1:0]       idx
);

  logic [MAX_REGIONS-1:0] mask_ext_s;
  logic [MAX_REG_W-1:0]   cur_ext_s;
  region_hit_t            hit_s;
  logic                   unused_idx_s;

  // Widen operands to helper width, then choose between first-region and next-region search.
  always_comb begin
    mask_ext_s                    = {MAX_REGIONS{1'b0}};
    mask_ext_s[NUM_REGIONS-1:0]   = mask;
    cur_ext_s                     = {MAX_REG_W{1'b0}};
    cur_ext_s[REG_W-1:0]          = cur;
    if (first) begin
      hit_s = lowest_set(mask_ext_s);
    end else begin
      hit_s = next_region(mask_ext_s, cur_ext_s);
    end
  end

  assign found        = hit_s.found;
  assign idx          = hit_s.idx[REG_W-1:0];
  // Upper index bits are always zero for in-range masks.
  assign unused_idx_s = ^hit_s.idx;

endmodule

// File: rtl/memory_flasher_mr.sv
// Boot-time flasher: streams a contiguous image ROM into NUM_REGIONS target memories.
module memory_flasher_mr
  import flasher_pkg::*;
#(
  parameter  int DATA_W      = 16,
  parameter  int ADDR_W      = 10,
  parameter  int NUM_REGIONS = 2,
  localparam int REG_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                    clk,
  input  logic                    async_rst_n,
  input  logic                    clk_en,
  input  logic                    flash_init,
  input  logic [NUM_REGIONS-1:0]  region_mask,
  output logic                    rom_rd_en,
  output logic [REG_W+ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic                    flash_valid,
  input  logic                    flash_ready,
  output logic [NUM_REGIONS-1:0]  flash_sel,
  output logic [ADDR_W-1:0]       flash_addr,
  output logic [DATA_W-1:0]       flash_data,
  output logic                    busy,
  output logic                    done_pulse,
  output logic                    system_enable
);

  localparam logic [ADDR_W-1:0] WORD_LAST = {ADDR_W{1'b1}};

  flasher_state_t         state_q, state_d;
  logic [REG_W-1:0]       region_q, region_d;
  logic [ADDR_W-1:0]      word_q, word_d;
  logic [NUM_REGIONS-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   fresh_q, fresh_d;
  logic                   done_q, done_d;

  logic [NUM_REGIONS-1:0] srch_mask_s;
  logic                   srch_first_s;
  logic                   srch_found_s;
  logic [REG_W-1:0]       srch_idx_s;

  // At run start search the incoming mask from bit 0; mid-run search the latched mask above the current region.
  always_comb begin
    if ((state_q == IDLE) || (state_q == DONE)) begin
      srch_mask_s  = region_mask;
      srch_first_s = 1'b1;
    end else begin
      srch_mask_s  = mask_q;
      srch_first_s = 1'b0;
    end
  end

  flash_region_select #(
    .NUM_REGIONS (NUM_REGIONS),
    .REG_W       (REG_W)
  ) u_region_select (
    .mask  (srch_mask_s),
    .cur   (region_q),
    .first (srch_first_s),
    .found (srch_found_s),
    .idx   (srch_idx_s)
  );

  // Next-state and datapath; nothing moves on a cycle without clk_en.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    word_d   = word_q;
    mask_d   = mask_q;
    data_d   = data_q;
    fresh_d  = fresh_q;
    done_d   = done_q;
    if (clk_en) begin
      done_d = 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (flash_init) begin
            mask_d = region_mask;
            word_d = {ADDR_W{1'b0}};
            if (srch_found_s) begin
              region_d = srch_idx_s;
              state_d  = FETCH;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        FETCH: begin
          // ROM answers during the first WRITE cycle; fresh_q marks that cycle.
          state_d = WRITE;
          fresh_d = 1'b1;
        end
        WRITE: begin
          if (fresh_q) begin
            data_d  = rom_data;
            fresh_d = 1'b0;
          end else begin
            data_d = data_q;
          end
          if (flash_ready) begin
            if (word_q != WORD_LAST) begin
              word_d  = word_q + ADDR_W'(1);
              state_d = FETCH;
            end else begin
              // Word counter wraps; the mask search alone decides termination.
              word_d = {ADDR_W{1'b0}};
              if (srch_found_s) begin
                region_d = srch_idx_s;
                state_d  = FETCH;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end else begin
            state_d = WRITE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      done_d = done_q;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q  <= IDLE;
      region_q <= {REG_W{1'b0}};
      word_q   <= {ADDR_W{1'b0}};
      mask_q   <= {NUM_REGIONS{1'b0}};
      data_q   <= {DATA_W{1'b0}};
      fresh_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      word_q   <= word_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      fresh_q  <= fresh_d;
      done_q   <= done_d;
    end
  end

  // Outputs decoded from registered state; write fields are zero outside WRITE.
  always_comb begin
    rom_rd_en     = (state_q == FETCH) && clk_en;
    rom_addr      = {region_q, word_q};
    flash_valid   = (state_q == WRITE);
    busy          = (state_q == FETCH) || (state_q == WRITE);
    system_enable = (state_q == DONE);
    done_pulse    = done_q;
    flash_sel     = {NUM_REGIONS{1'b0}};
    for (int i = 0; i < NUM_REGIONS; i++) begin
      flash_sel[i] = flash_valid && (region_q == REG_W'(i));
    end
    if (!flash_valid) begin
      flash_addr = {ADDR_W{1'b0}};
      flash_data = {DATA_W{1'b0}};
    end else if (fresh_q) begin
      flash_addr = word_q;
      flash_data = rom_data;
    end else begin
      flash_addr = word_q;
      flash_data = data_q;
    end
  end

endmodule

// File: tb/tb_memory_flasher_mr.sv
// Self-checking bench: table-driven runs, random runs and hand-written corner sequences.
module tb_memory_flasher_mr;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 2;
  localparam int NUM_REGIONS = 3;
  localparam int DEPTH       = 4;

  logic                   clk = 1'b0;
  logic                   async_rst_n;
  logic                   clk_en;
  logic                   flash_init;
  logic [NUM_REGIONS-1:0] region_mask;
  logic                   rom_rd_en;
  logic [3:0]             rom_addr;
  logic [DATA_W-1:0]      rom_data;
  logic                   flash_valid;
  logic                   flash_ready;
  logic [NUM_REGIONS-1:0] flash_sel;
  logic [ADDR_W-1:0]      flash_addr;
  logic [DATA_W-1:0]      flash_data;
  logic                   busy;
  logic                   done_pulse;
  logic                   system_enable;

  typedef struct packed {
    logic [2:0]  sel;
    logic [1:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [2:0] mask;
    int         mode;       // 0 full rate, 1 random clk_en/ready, 2 clk_en toggling
    int         exp_writes;
    int         exp_last;   // cycles from start to last write, -1 when not timed
    int         exp_done;   // cycles from start to counted done_pulse, -1 when not timed
  } vec_t;

  int         n_tests     = 0;
  int         n_fail      = 0;
  int         cyc         = 0;
  int         done_cnt    = 0;
  int         done_cyc    = 0;
  int         last_wr_cyc = 0;
  int         bad_rom_cnt = 0;
  int         start_cyc   = 0;
  logic [2:0] run_mask    = 3'b000;
  wr_t        obs_q[$];

  always #5 clk = ~clk;

  memory_flasher_mr #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS)
  ) dut (
    .clk           (clk),
    .async_rst_n   (async_rst_n),
    .clk_en        (clk_en),
    .flash_init    (flash_init),
    .region_mask   (region_mask),
    .rom_rd_en     (rom_rd_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .flash_valid   (flash_valid),
    .flash_ready   (flash_ready),
    .flash_sel     (flash_sel),
    .flash_addr    (flash_addr),
    .flash_data    (flash_data),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .system_enable (system_enable)
  );

  // Image ROM: word i holds 0x100+i, synchronous read one enabled cycle after the strobe.
  always @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) rom_data <= 16'h0000;
    else if (rom_rd_en) rom_data <= 16'h0100 + 16'(rom_addr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observe transfers, counted done pulses and ROM reads mid-cycle.
  always @(negedge clk) begin
    if (flash_valid && flash_ready && clk_en) begin
      obs_q.push_back({flash_sel, flash_addr, flash_data});
      last_wr_cyc = cyc;
    end
    if (done_pulse && clk_en) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rom_rd_en && ((rom_addr[3:2] > 2'd2) || !run_mask[rom_addr[3:2]])) bad_rom_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [2:0] m);
    run_mask    = m;
    region_mask = m;
    flash_init  = 1'b1;
    clk_en      = 1'b1;
    start_cyc   = cyc;
    tick();
    flash_init  = 1'b0;
    region_mask = 3'($urandom);
  endtask

  task automatic finish_run(input int mode, input int d0);
    int c;
    c = 0;
    while ((done_cnt == d0) && (c < 400)) begin
      case (mode)
        1: begin
          clk_en      = ($urandom_range(0, 3) != 0);
          flash_ready = ($urandom_range(0, 1) == 1);
          flash_init  = busy && ($urandom_range(0, 1) == 1);
          region_mask = 3'($urandom);
        end
        2: begin
          clk_en      = ~clk_en;
          flash_ready = 1'b1;
        end
        default: begin
          clk_en      = 1'b1;
          flash_ready = 1'b1;
        end
      endcase
      tick();
      c++;
    end
    flash_init  = 1'b0;
    clk_en      = 1'b1;
    flash_ready = 1'b1;
    tick();
    check("run_done_pulses", 32'(done_cnt - d0), 32'd1);
  endtask

  // Reference: every selected region in ascending order, all its words, ROM word r*DEPTH+w.
  task automatic check_writes(input logic [2:0] m);
    wr_t exp_q[$];
    wr_t e;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (m[r]) begin
        for (int w = 0; w < DEPTH; w++) begin
          e.sel  = 3'(1 << r);
          e.addr = 2'(w);
          e.data = 16'h0100 + 16'(r * DEPTH + w);
          exp_q.push_back(e);
        end
      end
    end
    check("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; (i < exp_q.size()) && (i < obs_q.size()); i++) begin
      check($sformatf("write[%0d] mask=%b", i, m), 32'(obs_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   c;
    int   d0;
    logic [2:0] m;

    async_rst_n = 1'b0;
    clk_en      = 1'b0;
    flash_init  = 1'b0;
    flash_ready = 1'b0;
    region_mask = 3'b000;

    vecs[0] = '{3'b011, 0, 8,  16, 17};
    vecs[1] = '{3'b101, 0, 8,  16, 17};
    vecs[2] = '{3'b010, 2, 4,  16, 18};
    vecs[3] = '{3'b001, 2, 4,  16, 18};
    vecs[4] = '{3'b111, 1, 12, -1, -1};
    vecs[5] = '{3'b100, 1, 4,  -1, -1};

    repeat (3) tick();
    check("rst_flash_valid", 32'(flash_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_system_enable", 32'(system_enable), 32'd0);
    check("rst_done_pulse", 32'(done_pulse), 32'd0);
    check("rst_rom_rd_en", 32'(rom_rd_en), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_flash_sel", 32'(flash_sel), 32'd0);

    async_rst_n = 1'b1;
    clk_en      = 1'b1;
    flash_ready = 1'b1;
    tick();
    tick();

    // Table-driven runs
    foreach (vecs[v]) begin
      obs_q.delete();
      bad_rom_cnt = 0;
      d0 = done_cnt;
      start_run(vecs[v].mask);
      check("vec_busy_after_start", 32'(busy), 32'd1);
      finish_run(vecs[v].mode, d0);
      check($sformatf("vec%0d_writes", v), 32'(obs_q.size()), 32'(vecs[v].exp_writes));
      check_writes(vecs[v].mask);
      check("vec_masked_rom_reads", 32'(bad_rom_cnt), 32'd0);
      check("vec_system_enable", 32'(system_enable), 32'd1);
      check("vec_busy_end", 32'(busy), 32'd0);
      if (vecs[v].exp_last >= 0) begin
        check($sformatf("vec%0d_last_write_cycle", v), 32'(last_wr_cyc - start_cyc), 32'(vecs[v].exp_last));
        check($sformatf("vec%0d_done_cycle", v), 32'(done_cyc - start_cyc), 32'(vecs[v].exp_done));
      end
    end

    // Random masks with random clk_en, ready stalls and ignored mid-run init/mask changes
    for (int k = 0; k < 8; k++) begin
      m = 3'($urandom_range(1, 7));
      obs_q.delete();
      bad_rom_cnt = 0;
      d0 = done_cnt;
      start_run(m);
      finish_run(1, d0);
      check_writes(m);
      check("rand_masked_rom_reads", 32'(bad_rom_cnt), 32'd0);
    end

    // Empty mask: straight to DONE, one pulse, no writes
    obs_q.delete();
    d0 = done_cnt;
    start_run(3'b000);
    check("zero_mask_done_pulse", 32'(done_pulse), 32'd1);
    check("zero_mask_system_enable", 32'(system_enable), 32'd1);
    check("zero_mask_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("zero_mask_done_count", 32'(done_cnt - d0), 32'd1);
    check("zero_mask_done_cycle", 32'(done_cyc - start_cyc), 32'd1);
    check("zero_mask_writes", 32'(obs_q.size()), 32'd0);

    // Ready stall at region 0 word 2
    obs_q.delete();
    d0 = done_cnt;
    flash_ready = 1'b1;
    start_run(3'b011);
    c = 0;
    while (!(flash_valid && (flash_sel == 3'b001) && (flash_addr == 2'd2)) && (c < 20)) begin
      tick();
      c++;
    end
    check("stall_reached", 32'(c < 20), 32'd1);
    flash_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("stall_valid", 32'(flash_valid), 32'd1);
      check("stall_addr", 32'(flash_addr), 32'd2);
      check("stall_data", 32'(flash_data), 32'h0102);
      tick();
    end
    check("stall_no_transfer", 32'(obs_q.size()), 32'd2);
    finish_run(0, d0);
    check_writes(3'b011);

    // Asynchronous reset in region 1 aborts without a done pulse
    obs_q.delete();
    d0 = done_cnt;
    start_run(3'b011);
    c = 0;
    while (!(flash_valid && (flash_sel == 3'b010) && (flash_addr == 2'd1)) && (c < 40)) begin
      tick();
      c++;
    end
    check("abort_reached", 32'(c < 40), 32'd1);
    #2;
    async_rst_n = 1'b0;
    #1;
    check("abort_flash_valid", 32'(flash_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_flash_sel", 32'(flash_sel), 32'd0);
    check("abort_system_enable", 32'(system_enable), 32'd0);
    check("abort_rom_rd_en", 32'(rom_rd_en), 32'd0);
    tick();
    async_rst_n = 1'b1;
    tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    obs_q.delete();
    start_run(3'b011);
    finish_run(0, d0);
    check_writes(3'b011);

    // Re-flash region 1 only after DONE
    check("reflash_sysen_before", 32'(system_enable), 32'd1);
    obs_q.delete();
    d0 = done_cnt;
    start_run(3'b010);
    check("reflash_sysen_drops", 32'(system_enable), 32'd0);
    check("reflash_busy", 32'(busy), 32'd1);
    finish_run(0, d0);
    check_writes(3'b010);
    check("reflash_sysen_after", 32'(system_enable), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
